// File: rtl/gemm_pkg.sv
// Shared definitions for the systolic GEMM engine: default geometry and FSM encoding.
package gemm_pkg;

  localparam int GEMM_S  = 4;
  localparam int GEMM_DW = 8;
  localparam int GEMM_AW = 32;
  localparam int GEMM_IW = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RDC   = 3'd4,
    ST_WRC   = 3'd5,
    ST_NEXT  = 3'd6
  } gemm_state_e;

endpackage

// File: rtl/gemm_pe.sv
// One processing element: forwards data right and weight down through 1-cycle
// registers and accumulates their product (signed or unsigned) modulo 2^AW.
module gemm_pe
  import gemm_pkg::*;
#(
  parameter int DW = GEMM_DW,
  parameter int AW = GEMM_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          sgn,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic [AW-1:0] acc
);

  logic [2*DW-1:0] a_ext;
  logic [2*DW-1:0] b_ext;
  logic [2*DW-1:0] prod;
  logic [AW-1:0]   prod_ext;

  // The true product always fits in 2*DW bits, so a 2*DW-bit multiply of the
  // extended operands yields the exact signed/unsigned result.
  always_comb begin
    a_ext    = {{DW{sgn & a_in[DW-1]}}, a_in};
    b_ext    = {{DW{sgn & b_in[DW-1]}}, b_in};
    prod     = a_ext * b_ext;
    prod_ext = {{(AW-2*DW){sgn & prod[2*DW-1]}}, prod};
  end

  // Pass registers and accumulator; clear empties the PE between tiles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (clear) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/systolic_gemm.sv
// Output-stationary S x S systolic GEMM: tiles C = A*B (or C += A*B) over
// external A/B/C buffers with one-cycle read latency.
//
//   state | meaning
//   IDLE  | waiting for in_valid
//   REQ   | issue operand index k=0 for the current tile
//   FEED  | K cycles: issue k=1..K-1, then one idle cycle
//   DRAIN | 2S-1 cycles for the skewed wavefront to reach PE(S-1,S-1)
//   RDC   | accumulate mode: issue C read for the current row
//   WRC   | write one C row (old+new when accumulating)
//   NEXT  | clear PEs, advance tile or finish with done
module systolic_gemm
  import gemm_pkg::*;
#(
  parameter int S  = GEMM_S,
  parameter int DW = GEMM_DW,
  parameter int AW = GEMM_AW,
  parameter int IW = GEMM_IW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [7:0]      K,
  input  logic [7:0]      M,
  input  logic [7:0]      N,
  input  logic            sgn,
  input  logic            acc,
  output logic            busy,
  output logic            done,
  output logic [IW-1:0]   A_index,
  output logic [IW-1:0]   B_index,
  input  logic [S*DW-1:0] A_data_out,
  input  logic [S*DW-1:0] B_data_out,
  output logic            C_wr_en,
  output logic [IW-1:0]   C_index,
  output logic [S*AW-1:0] C_data_in,
  input  logic [S*AW-1:0] C_data_out
);

  localparam int         WW       = $clog2(S);
  localparam logic [8:0] S9       = 9'(S);
  localparam logic [7:0] DRAIN_M1 = 8'(2*S-2);

  gemm_state_e state_q, state_d;

  logic [7:0]    k_q, m_q, n_q;
  logic          sgn_q, acc_q;
  logic [7:0]    tmr_q;
  logic [WW-1:0] w_q;
  logic [8:0]    row_base_q, col_base_q;
  logic [IW-1:0] a_base_q, b_base_q, c_base_q;
  logic          fv_q;

  logic          dims_ok, issue, last_r, last_c, last_row, pe_clear;
  logic [7:0]    k_cur;
  logic [8:0]    rows_left, rows_m1;
  logic [AW-1:0] lane_sum;

  logic [DW-1:0] a_row  [S];
  logic [DW-1:0] b_col  [S];
  logic [DW-1:0] a_pass [S][S];
  logic [DW-1:0] b_pass [S][S];
  logic [AW-1:0] pe_acc [S][S];

  assign dims_ok   = (K != 8'd0) && (M != 8'd0) && (N != 8'd0);
  assign rows_left = {1'b0, m_q} - row_base_q;
  assign last_r    = rows_left <= S9;
  assign last_c    = ({1'b0, n_q} - col_base_q) <= S9;
  assign rows_m1   = (last_r ? rows_left : S9) - 9'd1;
  assign last_row  = ({{(9-WW){1'b0}}, w_q} == rows_m1);
  assign issue     = (state_q == ST_REQ) || ((state_q == ST_FEED) && (tmr_q != 8'd0));
  assign k_cur     = (state_q == ST_REQ) ? 8'd0 : k_q - tmr_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and control outputs.
  always_comb begin
    state_d  = state_q;
    busy     = (state_q != ST_IDLE);
    done     = 1'b0;
    C_wr_en  = 1'b0;
    pe_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (dims_ok) state_d = ST_REQ;
          else         done    = 1'b1;
        end
      end
      ST_REQ:   state_d = ST_FEED;
      ST_FEED:  if (tmr_q == 8'd0) state_d = ST_DRAIN;
      ST_DRAIN: if (tmr_q == 8'd0) state_d = acc_q ? ST_RDC : ST_WRC;
      ST_RDC:   state_d = ST_WRC;
      ST_WRC: begin
        C_wr_en = 1'b1;
        if (last_row) state_d = ST_NEXT;
        else          state_d = acc_q ? ST_RDC : ST_WRC;
      end
      ST_NEXT: begin
        pe_clear = 1'b1;
        if (last_r && last_c) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end else begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Buffer index generation; everything reads as zero outside issue/write states.
  always_comb begin
    A_index = '0;
    B_index = '0;
    C_index = '0;
    if (issue) begin
      A_index = a_base_q + IW'(k_cur);
      B_index = b_base_q + IW'(k_cur);
    end
    if ((state_q == ST_RDC) || (state_q == ST_WRC))
      C_index = c_base_q + IW'(row_base_q) + IW'(w_q);
  end

  // Job parameters, phase timer, row counter and tile bases.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q        <= '0;
      m_q        <= '0;
      n_q        <= '0;
      sgn_q      <= 1'b0;
      acc_q      <= 1'b0;
      tmr_q      <= '0;
      w_q        <= '0;
      row_base_q <= '0;
      col_base_q <= '0;
      a_base_q   <= '0;
      b_base_q   <= '0;
      c_base_q   <= '0;
      fv_q       <= 1'b0;
    end else begin
      fv_q <= issue;
      case (state_q)
        ST_IDLE: begin
          if (in_valid && dims_ok) begin
            k_q        <= K;
            m_q        <= M;
            n_q        <= N;
            sgn_q      <= sgn;
            acc_q      <= acc;
            w_q        <= '0;
            row_base_q <= '0;
            col_base_q <= '0;
            a_base_q   <= '0;
            b_base_q   <= '0;
            c_base_q   <= '0;
          end
        end
        ST_REQ:  tmr_q <= k_q - 8'd1;
        ST_FEED: tmr_q <= (tmr_q == 8'd0) ? DRAIN_M1 : tmr_q - 8'd1;
        ST_DRAIN: begin
          if (tmr_q != 8'd0) tmr_q <= tmr_q - 8'd1;
          w_q <= '0;
        end
        ST_WRC: w_q <= w_q + 1'b1;
        ST_NEXT: begin
          w_q <= '0;
          if (last_r) begin
            row_base_q <= '0;
            a_base_q   <= '0;
            if (!last_c) begin
              col_base_q <= col_base_q + S9;
              b_base_q   <= b_base_q + IW'(k_q);
              c_base_q   <= c_base_q + IW'(m_q);
            end
          end else begin
            row_base_q <= row_base_q + S9;
            a_base_q   <= a_base_q + IW'(k_q);
          end
        end
        default: ;
      endcase
    end
  end

  // Operand lanes: mask non-issued reads to zero, then skew lane i by i cycles.
  for (genvar i = 0; i < S; i++) begin : g_lane
    logic [DW-1:0] a_raw, b_raw;
    assign a_raw = fv_q ? A_data_out[(S-1-i)*DW +: DW] : '0;
    assign b_raw = fv_q ? B_data_out[(S-1-i)*DW +: DW] : '0;
    if (i == 0) begin : g_nodly
      assign a_row[i] = a_raw;
      assign b_col[i] = b_raw;
    end else begin : g_dly
      logic [DW-1:0] a_sr [0:i-1];
      logic [DW-1:0] b_sr [0:i-1];
      // Skew shift registers for this lane.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int s = 0; s < i; s++) begin
            a_sr[s] <= '0;
            b_sr[s] <= '0;
          end
        end else begin
          a_sr[0] <= a_raw;
          b_sr[0] <= b_raw;
          for (int s = 1; s < i; s++) begin
            a_sr[s] <= a_sr[s-1];
            b_sr[s] <= b_sr[s-1];
          end
        end
      end
      assign a_row[i] = a_sr[i-1];
      assign b_col[i] = b_sr[i-1];
    end
  end

  for (genvar i = 0; i < S; i++) begin : g_row
    for (genvar j = 0; j < S; j++) begin : g_col
      logic [DW-1:0] a_in_w, b_in_w;
      if (j == 0) begin : g_ain
        assign a_in_w = a_row[i];
      end else begin : g_apass
        assign a_in_w = a_pass[i][j-1];
      end
      if (i == 0) begin : g_bin
        assign b_in_w = b_col[j];
      end else begin : g_bpass
        assign b_in_w = b_pass[i-1][j];
      end
      gemm_pe #(.DW(DW), .AW(AW)) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (pe_clear),
        .sgn   (sgn_q),
        .a_in  (a_in_w),
        .b_in  (b_in_w),
        .a_out (a_pass[i][j]),
        .b_out (b_pass[i][j]),
        .acc   (pe_acc[i][j])
      );
    end
  end

  // Row writeback data: optional read-modify-write, lanes past N forced to zero.
  always_comb begin
    C_data_in = '0;
    lane_sum  = '0;
    for (int j = 0; j < S; j++) begin
      lane_sum = pe_acc[w_q][j] + (acc_q ? C_data_out[(S-1-j)*AW +: AW] : '0);
      if ((col_base_q + 9'(j)) < {1'b0, n_q})
        C_data_in[(S-1-j)*AW +: AW] = lane_sum;
    end
  end

endmodule
